// File: rtl/demux_stream_pkg.sv
// Shared types and constants for demux_stream.
//   FIFO_DEPTH : entries per output FIFO (the design supports only 2)
//   CNT_W      : width of the per-channel accept counters
//   state_e    : channel FSM encoding (CH0=0, CH1=1)
//   mode_e     : routing mode encoding (select=0, alternate=1)
//   dbg_t      : layout of the optional debug word
package demux_stream_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W      = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } state_e;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_ALT    = 1'b1
  } mode_e;

  typedef struct packed {
    state_e               state;
    logic [FIFO_CW-1:0]   fifo0_cnt;
    logic [FIFO_CW-1:0]   fifo1_cnt;
    logic                 target;
    logic                 accept;
    logic                 in_valid;
    logic                 mode;
  } dbg_t;

  localparam int unsigned DBG_W = $bits(dbg_t);

endpackage

// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one upstream port, two downstream ports.
//   master : the environment side (drives in_valid/in_data and outN_ready)
//   slave  : the demux side (drives in_ready, outN_valid, outN_data)
interface demux_stream_if #(
  parameter int unsigned W = 8
) ();

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;

  logic         out0_valid;
  logic [W-1:0] out0_data;
  logic         out0_ready;

  logic         out1_valid;
  logic [W-1:0] out1_data;
  logic         out1_ready;

  modport master (
    output in_valid, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

endinterface

// File: rtl/demux_fifo2.sv
// Small synchronous FIFO (DEPTH entries, 2 supported) with head-of-queue output.
//   clk, rst   : clock, synchronous active-high reset
//   push/data  : write request and payload (ignored when full)
//   pop        : read request (ignored when empty)
//   head       : oldest entry, valid while !empty
//   full/empty : occupancy flags, count : number of entries held
module demux_fifo2 #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Pointer/count update; push and pop in the same cycle leave count unchanged.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/demux_stream.sv
// One-to-two stream demultiplexer with a 2-entry FIFO per output channel.
//   clk, rst   : clock, synchronous active-high reset
//   mode       : 0 = route by S, 1 = alternate channels per accepted beat
//   S          : channel select in select mode
//   bus        : upstream in_* and downstream out0_*/out1_* handshakes
//   cnt0, cnt1 : accepted-beat counters per channel (wrap at 256)
//   dbg        : present only with DEMUX_STREAM_DEBUG_EN defined;
//                {state, fifo0 count, fifo1 count, target, accept, in_valid, mode}
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             S,
  demux_stream_if.slave    bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`ifdef DEMUX_STREAM_DEBUG_EN
  ,
  output logic [DBG_W-1:0] dbg
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  state_e             target;
  logic               in_ready_c;
  logic               accept;
  logic               push0, push1, pop0, pop1;
  logic               full0, full1, empty0, empty1;
  logic [FIFO_CW-1:0] fifo0_cnt, fifo1_cnt;

  demux_fifo2 #(.W(W), .DEPTH(DEPTH), .CW(FIFO_CW)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (bus.in_data),
    .pop       (pop0),
    .head      (bus.out0_data),
    .full      (full0),
    .empty     (empty0),
    .count     (fifo0_cnt)
  );

  demux_fifo2 #(.W(W), .DEPTH(DEPTH), .CW(FIFO_CW)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (bus.in_data),
    .pop       (pop1),
    .head      (bus.out1_data),
    .full      (full1),
    .empty     (empty1),
    .count     (fifo1_cnt)
  );

  // Routing, handshake and next-state. A full target refuses the beat even if
  // it is being popped this cycle, so there is no full-to-full pass-through.
  always_comb begin
    target     = CH0;
    state_d    = state_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;

    if (mode_e'(mode) == MODE_ALT) begin
      target = state_q;
    end else begin
      target = S ? CH1 : CH0;
    end

    // Reset cycles never accept, so ready is withheld while rst is high.
    in_ready_c = !rst && !((target == CH1) ? full1 : full0);
    accept     = bus.in_valid && in_ready_c;
    push0      = accept && (target == CH0);
    push1      = accept && (target == CH1);
    pop0       = bus.out0_ready && !empty0;
    pop1       = bus.out1_ready && !empty1;

    // Select mode parks the FSM on CH0 so alternate mode always starts there.
    if (mode_e'(mode) == MODE_SELECT) begin
      state_d = CH0;
    end else if (accept) begin
      state_d = (state_q == CH0) ? CH1 : CH0;
    end

    cnt0_d = cnt0_q + CNT_W'(push0);
    cnt1_d = cnt1_q + CNT_W'(push1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out0_valid = !empty0;
  assign bus.out1_valid = !empty1;
  assign cnt0           = cnt0_q;
  assign cnt1           = cnt1_q;

`ifdef DEMUX_STREAM_DEBUG_EN
  dbg_t dbg_s;

  always_comb begin
    dbg_s           = '0;
    dbg_s.state     = state_q;
    dbg_s.fifo0_cnt = fifo0_cnt;
    dbg_s.fifo1_cnt = fifo1_cnt;
    dbg_s.target    = target;
    dbg_s.accept    = accept;
    dbg_s.in_valid  = bus.in_valid;
    dbg_s.mode      = mode;
  end

  assign dbg = dbg_s;
`else
  logic unused_fifo_cnt;
  assign unused_fifo_cnt = ^{fifo0_cnt, fifo1_cnt};
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed vector table, hand-written
// corner sequences, counter wrap and random traffic against a queue model.
module tb_demux_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       s_sel;
  logic [7:0] cnt0, cnt1;
`ifdef DEMUX_STREAM_DEBUG_EN
  logic [8:0] dbg;
`endif

  demux_stream_if #(.W(8)) bus ();

  demux_stream #(.W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .S    (s_sel),
    .bus  (bus),
    .cnt0 (cnt0),
    .cnt1 (cnt1)
`ifdef DEMUX_STREAM_DEBUG_EN
    ,
    .dbg  (dbg)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per channel, counters and the alternate pointer.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         m_cnt0, m_cnt1;
  bit         alt_ch;

  // Values sampled in the most recent step (before its clock edge).
  logic       s_rdy, s_v0, s_v1;
  logic [7:0] s_d0, s_d1, s_c0, s_c1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
    alt_ch = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mode = 1'b0; s_sel = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_reset();
  endtask

  // One clock cycle: drive at negedge, check against the model, then advance it.
  task automatic step(input logic r, input logic m, input logic s, input logic iv,
                      input logic [7:0] d, input logic rd0, input logic rd1);
    bit tgt, acc;
    @(negedge clk);
    rst = r; mode = m; s_sel = s;
    bus.in_valid = iv; bus.in_data = d;
    bus.out0_ready = rd0; bus.out1_ready = rd1;
    #1;
    s_rdy = bus.in_ready; s_v0 = bus.out0_valid; s_d0 = bus.out0_data;
    s_v1 = bus.out1_valid; s_d1 = bus.out1_data; s_c0 = cnt0; s_c1 = cnt1;

    tgt = m ? alt_ch : s;
    acc = !r && iv && ((tgt ? q1.size() : q0.size()) < 2);

    if (!r) chk("in_ready", s_rdy, (tgt ? q1.size() : q0.size()) < 2);
    chk("out0_valid", s_v0, q0.size() != 0);
    chk("out1_valid", s_v1, q1.size() != 0);
    if (q0.size() != 0) chk("out0_data", s_d0, q0[0]);
    if (q1.size() != 0) chk("out1_data", s_d1, q1[0]);
    chk("cnt0", s_c0, m_cnt0 % 256);
    chk("cnt1", s_c1, m_cnt1 % 256);
`ifdef DEMUX_STREAM_DEBUG_EN
    begin
      logic [8:0] exp_dbg;
      exp_dbg = {alt_ch, 2'(q0.size()), 2'(q1.size()), tgt, acc, iv, m};
      chk("dbg", dbg, exp_dbg);
    end
`endif

    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (rd0 && q0.size() != 0) void'(q0.pop_front());
      if (rd1 && q1.size() != 0) void'(q1.pop_front());
      if (acc) begin
        if (tgt) begin q1.push_back(d); m_cnt1++; end
        else     begin q0.push_back(d); m_cnt0++; end
      end
      if (!m)       alt_ch = 1'b0;
      else if (acc) alt_ch = ~alt_ch;
    end
  endtask

  typedef struct {
    logic       mode, s, iv;
    logic [7:0] d;
    logic       r0, r1;
    logic       e_rdy, e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1, e_c0, e_c1;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst = 1'b1; mode = 1'b0; s_sel = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;

    // mode s iv d r0 r1 | rdy v0 d0 v1 d1 c0 c1
    tbl[0]  = '{0,0,1,8'h11,1,1, 1,0,8'h00,0,8'h00,8'd0,8'd0};
    tbl[1]  = '{0,0,1,8'h22,1,1, 1,1,8'h11,0,8'h00,8'd1,8'd0};
    tbl[2]  = '{0,0,0,8'h00,1,1, 1,1,8'h22,0,8'h00,8'd2,8'd0};
    tbl[3]  = '{0,0,0,8'h00,1,1, 1,0,8'h00,0,8'h00,8'd2,8'd0};
    tbl[4]  = '{1,0,1,8'hA0,0,0, 1,0,8'h00,0,8'h00,8'd2,8'd0};
    tbl[5]  = '{1,0,1,8'hA1,0,0, 1,1,8'hA0,0,8'h00,8'd3,8'd0};
    tbl[6]  = '{1,0,1,8'hA2,0,0, 1,1,8'hA0,1,8'hA1,8'd3,8'd1};
    tbl[7]  = '{1,0,1,8'hA3,0,0, 1,1,8'hA0,1,8'hA1,8'd4,8'd1};
    tbl[8]  = '{1,0,1,8'hA4,1,0, 0,1,8'hA0,1,8'hA1,8'd4,8'd2};
    tbl[9]  = '{1,0,1,8'hA4,0,0, 1,1,8'hA2,1,8'hA1,8'd4,8'd2};
    tbl[10] = '{1,0,0,8'h00,1,1, 0,1,8'hA2,1,8'hA1,8'd5,8'd2};
    tbl[11] = '{1,0,0,8'h00,1,1, 1,1,8'hA4,1,8'hA3,8'd5,8'd2};
    tbl[12] = '{0,1,0,8'h00,1,1, 1,0,8'h00,0,8'h00,8'd5,8'd2};

    do_reset();

    // Directed table: select-mode traffic, then alternate mode with full FIFOs.
    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].mode, tbl[i].s, tbl[i].iv, tbl[i].d, tbl[i].r0, tbl[i].r1);
      chk($sformatf("tbl%0d_rdy", i), s_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_v0", i), s_v0, tbl[i].e_v0);
      chk($sformatf("tbl%0d_v1", i), s_v1, tbl[i].e_v1);
      if (tbl[i].e_v0) chk($sformatf("tbl%0d_d0", i), s_d0, tbl[i].e_d0);
      if (tbl[i].e_v1) chk($sformatf("tbl%0d_d1", i), s_d1, tbl[i].e_d1);
      chk($sformatf("tbl%0d_c0", i), s_c0, tbl[i].e_c0);
      chk($sformatf("tbl%0d_c1", i), s_c1, tbl[i].e_c1);
    end

    // Channel 1 back-pressure: third beat stalls until the head is popped.
    do_reset();
    step(0, 0, 1, 1, 8'hB0, 0, 0); chk("bp_rdy1", s_rdy, 1'b1);
    step(0, 0, 1, 1, 8'hB1, 0, 0); chk("bp_rdy2", s_rdy, 1'b1); chk("bp_head", s_d1, 8'hB0);
    step(0, 0, 1, 1, 8'hB2, 0, 0); chk("bp_stall", s_rdy, 1'b0);
    step(0, 0, 1, 1, 8'hB2, 0, 1); chk("bp_fullpop", s_rdy, 1'b0); chk("bp_pop0", s_d1, 8'hB0);
    step(0, 0, 1, 1, 8'hB2, 0, 1); chk("bp_accept", s_rdy, 1'b1); chk("bp_pop1", s_d1, 8'hB1);
    step(0, 0, 1, 0, 8'h00, 0, 1); chk("bp_pop2", s_d1, 8'hB2); chk("bp_cnt1", s_c1, 8'd3);
    step(0, 0, 1, 0, 8'h00, 0, 1); chk("bp_empty", s_v1, 1'b0);

    // Reset with data in both FIFOs and the FSM on CH1.
    do_reset();
    step(0, 1, 0, 1, 8'hC0, 0, 0);
    step(0, 1, 0, 1, 8'hC1, 0, 0);
    step(0, 1, 0, 1, 8'hC2, 0, 0);
    step(1, 1, 0, 1, 8'hC3, 0, 0);
    step(0, 1, 0, 1, 8'hD0, 0, 0);
    chk("rst_v0", s_v0, 1'b0); chk("rst_v1", s_v1, 1'b0);
    chk("rst_c0", s_c0, 8'd0); chk("rst_c1", s_c1, 8'd0); chk("rst_rdy", s_rdy, 1'b1);
    step(0, 0, 0, 0, 8'h00, 0, 0);
    chk("rst_fsm_ch0", s_v0, 1'b1); chk("rst_fsm_d0", s_d0, 8'hD0); chk("rst_fsm_v1", s_v1, 1'b0);

    // Counter wrap: 256 accepts into channel 0.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 0, 1, 8'(i), 1, 0);
      if (i == 255) chk("wrap_255", s_c0, 8'd255);
    end
    step(0, 0, 0, 0, 8'h00, 1, 0);
    chk("wrap_0", s_c0, 8'd0);
    chk("wrap_c1", s_c1, 8'd0);

    // Random traffic, including occasional resets and mode changes.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           8'($urandom),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
